// File: rtl/psg_bus_sequencer_if.sv
// rtl/psg_bus_sequencer_if.sv - requester handshakes and sound-chip write bus
interface psg_bus_sequencer_if;
  logic       saa_enabled;
  logic       z_req;
  logic [1:0] z_sel;
  logic       z_a0;
  logic [7:0] z_data;
  logic       z_ack;
  logic       a_req;
  logic [1:0] a_sel;
  logic       a_a0;
  logic [7:0] a_data;
  logic       a_ack;
  logic [7:0] bus_d;
  logic       bus_a0;
  logic [1:0] ym_cs_n;
  logic       saa_cs_n;
  logic       wr_n;
  logic       bus_oe;
  logic       busy;

  // Requester/environment side
  modport master (
    output saa_enabled,
    output z_req, z_sel, z_a0, z_data,
    output a_req, a_sel, a_a0, a_data,
    input  z_ack, a_ack,
    input  bus_d, bus_a0, ym_cs_n, saa_cs_n, wr_n, bus_oe, busy
  );

  // Sequencer side
  modport slave (
    input  saa_enabled,
    input  z_req, z_sel, z_a0, z_data,
    input  a_req, a_sel, a_a0, a_data,
    output z_ack, a_ack,
    output bus_d, bus_a0, ym_cs_n, saa_cs_n, wr_n, bus_oe, busy
  );
endinterface

// File: rtl/psg_bus_sequencer.sv
// rtl/psg_bus_sequencer.sv - arbitrates two requesters onto the YM2203/SAA1099 write bus
module psg_bus_sequencer #(
  parameter int SETUP_CYC   = 2,
  parameter int WR_CYC      = 4,
  parameter int HOLD_CYC    = 2,
  parameter int REC_YM_ADDR = 288,
  parameter int REC_YM_DATA = 1344,
  parameter int REC_SAA     = 8
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  psg_bus_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  // Target code 3 marks a write that has no chip to talk to
  localparam logic [1:0] TGT_SAA  = 2'd2;
  localparam logic [1:0] TGT_NULL = 2'd3;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [1:0]  tgt_q, tgt_d;
  logic        last_grant_q, last_grant_d;   // 1 = aux requester
  logic [1:0]  ym_cs_n_q, ym_cs_n_d;
  logic        saa_cs_n_q, saa_cs_n_d;
  logic        wr_n_q, wr_n_d;
  logic        bus_oe_q, bus_oe_d;
  logic [7:0]  bus_d_q, bus_d_d;
  logic        bus_a0_q, bus_a0_d;
  logic        z_ack_q, z_ack_d;
  logic        a_ack_q, a_ack_d;
  logic        busy_q, busy_d;

  logic        z_pend, a_pend, pick_aux, g_null, g_a0;
  logic [1:0]  g_sel;
  logic [7:0]  g_data;
  logic [10:0] rec_cnt;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    last_grant_d = last_grant_q;
    ym_cs_n_d    = ym_cs_n_q;
    saa_cs_n_d   = saa_cs_n_q;
    wr_n_d       = wr_n_q;
    bus_oe_d     = bus_oe_q;
    bus_d_d      = bus_d_q;
    bus_a0_d     = bus_a0_q;
    z_ack_d      = 1'b0;
    a_ack_d      = 1'b0;

    // A requester whose ack is visible this cycle has not yet had a chance
    // to drop req, so it is not treated as pending.
    z_pend   = bus.z_req && !z_ack_q;
    a_pend   = bus.a_req && !a_ack_q;
    pick_aux = a_pend && (!z_pend || !last_grant_q);
    g_sel    = pick_aux ? bus.a_sel  : bus.z_sel;
    g_a0     = pick_aux ? bus.a_a0   : bus.z_a0;
    g_data   = pick_aux ? bus.a_data : bus.z_data;
    g_null   = (g_sel == TGT_NULL) || ((g_sel == TGT_SAA) && !bus.saa_enabled);

    if (tgt_q == TGT_SAA) begin
      rec_cnt = 11'(REC_SAA);
    end else if (bus_a0_q) begin
      rec_cnt = 11'(REC_YM_DATA);
    end else begin
      rec_cnt = 11'(REC_YM_ADDR);
    end

    case (state_q)
      S_IDLE: begin
        if (z_pend || a_pend) begin
          last_grant_d = pick_aux;
          cnt_d        = 11'(SETUP_CYC);
          state_d      = S_SETUP;
          if (g_null) begin
            tgt_d = TGT_NULL;
          end else begin
            tgt_d      = g_sel;
            bus_d_d    = g_data;
            bus_a0_d   = g_a0;
            bus_oe_d   = 1'b1;
            ym_cs_n_d  = {g_sel != 2'd1, g_sel != 2'd0};
            saa_cs_n_d = (g_sel != TGT_SAA);
          end
        end
      end
      S_SETUP: begin
        if (tgt_q == TGT_NULL) begin
          z_ack_d = !last_grant_q;
          a_ack_d = last_grant_q;
          state_d = S_IDLE;
        end else if (cnt_q <= 11'd1) begin
          wr_n_d  = 1'b0;
          cnt_d   = 11'(WR_CYC);
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q <= 11'd1) begin
          wr_n_d  = 1'b1;
          cnt_d   = 11'(HOLD_CYC);
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q <= 11'd1) begin
          ym_cs_n_d  = 2'b11;
          saa_cs_n_d = 1'b1;
          bus_oe_d   = 1'b0;
          z_ack_d    = !last_grant_q;
          a_ack_d    = last_grant_q;
          cnt_d      = rec_cnt;
          state_d    = S_RECOVER;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q <= 11'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tgt_q        <= TGT_NULL;
      last_grant_q <= 1'b1;
      ym_cs_n_q    <= 2'b11;
      saa_cs_n_q   <= 1'b1;
      wr_n_q       <= 1'b1;
      bus_oe_q     <= 1'b0;
      bus_d_q      <= '0;
      bus_a0_q     <= 1'b0;
      z_ack_q      <= 1'b0;
      a_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      last_grant_q <= last_grant_d;
      ym_cs_n_q    <= ym_cs_n_d;
      saa_cs_n_q   <= saa_cs_n_d;
      wr_n_q       <= wr_n_d;
      bus_oe_q     <= bus_oe_d;
      bus_d_q      <= bus_d_d;
      bus_a0_q     <= bus_a0_d;
      z_ack_q      <= z_ack_d;
      a_ack_q      <= a_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ym_cs_n  = ym_cs_n_q;
  assign bus.saa_cs_n = saa_cs_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.bus_oe   = bus_oe_q;
  assign bus.bus_d    = bus_d_q;
  assign bus.bus_a0   = bus_a0_q;
  assign bus.z_ack    = z_ack_q;
  assign bus.a_ack    = a_ack_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// tb/tb_psg_bus_sequencer.sv - scoreboard bench for psg_bus_sequencer
module tb_psg_bus_sequencer;

  localparam int CS_LEN   = 8;
  localparam int WR_LEN   = 4;
  localparam int WR_START = 3;
  localparam int ACK_WAIT = 4000;

  logic fclk;
  logic rst_n;
  psg_bus_sequencer_if bus_if ();

  psg_bus_sequencer dut (
    .fclk  (fclk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  typedef struct {
    bit         who;    // 0 = Z80, 1 = aux
    int         chip;   // 0 YM0, 1 YM1, 2 SAA, 3 none
    logic       a0;
    logic [7:0] d;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_last = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rec_of(input int chip, input logic a0);
    if (chip == 2) return 8;
    return a0 ? 1344 : 288;
  endfunction

  function automatic void push_exp(input bit who, input logic [1:0] sel,
                                   input logic a0, input logic [7:0] d);
    exp_t e;
    e.who  = who;
    e.chip = (sel == 2'd3 || (sel == 2'd2 && !bus_if.saa_enabled)) ? 3 : int'(sel);
    e.a0   = a0;
    e.d    = d;
    expq.push_back(e);
    m_last = who;
  endfunction

  task automatic wait_ack(input bit who);
    bit got = 0;
    for (int i = 0; i < ACK_WAIT; i++) begin
      @(negedge fclk);
      if ((who ? bus_if.a_ack : bus_if.z_ack) === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) chk(who ? "a_ack_timeout" : "z_ack_timeout", 0, 1);
  endtask

  task automatic run_req(input bit who, input logic [1:0] sel,
                         input logic a0, input logic [7:0] d);
    if (!who) begin
      bus_if.z_sel = sel; bus_if.z_a0 = a0; bus_if.z_data = d; bus_if.z_req = 1'b1;
    end else begin
      bus_if.a_sel = sel; bus_if.a_a0 = a0; bus_if.a_data = d; bus_if.a_req = 1'b1;
    end
    wait_ack(who);
    @(posedge fclk); #1;
    if (!who) bus_if.z_req = 1'b0;
    else      bus_if.a_req = 1'b0;
  endtask

  task automatic single(input bit who, input logic [1:0] sel,
                        input logic a0, input logic [7:0] d);
    push_exp(who, sel, a0, d);
    run_req(who, sel, a0, d);
  endtask

  task automatic both(input logic [1:0] zs, input logic za, input logic [7:0] zd,
                      input logic [1:0] as, input logic aa, input logic [7:0] ad);
    if (m_last) begin
      push_exp(0, zs, za, zd); push_exp(1, as, aa, ad);
    end else begin
      push_exp(1, as, aa, ad); push_exp(0, zs, za, zd);
    end
    fork
      run_req(0, zs, za, zd);
      run_req(1, as, aa, ad);
    join
  endtask

  // Monitor: observes the chip bus and acks and checks them against the queue
  int   cyc = 0;
  bit   in_win = 0, win_done = 0, win_bad = 0;
  int   win_len, wr_first, wr_cnt, win_rise, win_since_ack = 0;
  int   w_chip;
  logic w_a0;
  logic [7:0] w_d;
  int   last_ack = -1, last_rec = 0;

  always @(negedge fclk) begin
    int   nlow;
    bit   cs_any;
    exp_t e;
    if (!rst_n) begin
      in_win = 0; win_done = 0; win_since_ack = 0; last_ack = -1;
    end else begin
      cyc++;
      nlow   = int'(!bus_if.ym_cs_n[0]) + int'(!bus_if.ym_cs_n[1]) + int'(!bus_if.saa_cs_n);
      cs_any = (nlow != 0);
      if (nlow > 1) chk("one_cs_low", nlow, 1);
      if (!bus_if.wr_n && !cs_any) chk("wr_without_cs", 0, 1);
      if (bus_if.bus_oe !== cs_any) chk("bus_oe_vs_cs", int'(bus_if.bus_oe), int'(cs_any));

      if (cs_any && !in_win) begin
        in_win   = 1; win_len = 1; win_bad = 0;
        w_chip   = !bus_if.ym_cs_n[0] ? 0 : (!bus_if.ym_cs_n[1] ? 1 : 2);
        w_a0     = bus_if.bus_a0;
        w_d      = bus_if.bus_d;
        wr_cnt   = bus_if.wr_n ? 0 : 1;
        wr_first = bus_if.wr_n ? 0 : 1;
        if (last_ack >= 0) begin
          checks++;
          if (cyc - last_ack < last_rec + 1) begin
            errors++;
            $display("FAIL recovery_gap: got %0d cycles required at least %0d", cyc - last_ack, last_rec + 1);
          end
        end
      end else if (cs_any && in_win) begin
        win_len++;
        if (!bus_if.wr_n) begin
          wr_cnt++;
          if (wr_first == 0) wr_first = win_len;
        end
        if (bus_if.bus_d !== w_d || bus_if.bus_a0 !== w_a0) win_bad = 1;
      end else if (!cs_any && in_win) begin
        in_win = 0;
        chk("cs_low_len", win_len, CS_LEN);
        chk("wr_low_len", wr_cnt, WR_LEN);
        chk("wr_fall_pos", wr_first, WR_START);
        chk("bus_stable", int'(win_bad), 0);
        win_done = 1; win_rise = cyc; win_since_ack++;
      end

      if (last_ack >= 0 && cyc == last_ack + last_rec - 1) chk("busy_in_recover", int'(bus_if.busy), 1);
      if (last_ack >= 0 && cyc == last_ack + last_rec)     chk("busy_after_recover", int'(bus_if.busy), 0);

      if (bus_if.z_ack && bus_if.a_ack) chk("dual_ack", 1, 0);
      if (bus_if.z_ack || bus_if.a_ack) begin
        if (expq.size() == 0) begin
          chk("unexpected_ack", int'(bus_if.a_ack), -1);
        end else begin
          e = expq.pop_front();
          chk("ack_who", int'(bus_if.a_ack), int'(e.who));
          if (e.chip == 3) begin
            chk("null_no_cs", win_since_ack, 0);
          end else begin
            chk("ack_windows", win_since_ack, 1);
            chk("ack_at_cs_rise", win_done ? cyc - win_rise : -1, 0);
            chk("write_chip", w_chip, e.chip);
            chk("write_a0", int'(w_a0), int'(e.a0));
            chk("write_data", int'(w_d), int'(e.d));
            last_ack = cyc;
            last_rec = rec_of(e.chip, e.a0);
          end
          win_since_ack = 0; win_done = 0;
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    bit got;
    logic [7:0] d1, d2;
    logic [1:0] zs, as;
    logic za, aa;
    int mode;

    rst_n = 1'b0;
    bus_if.saa_enabled = 1'b1;
    bus_if.z_req = 0; bus_if.z_sel = 0; bus_if.z_a0 = 0; bus_if.z_data = 0;
    bus_if.a_req = 0; bus_if.a_sel = 0; bus_if.a_a0 = 0; bus_if.a_data = 0;
    repeat (3) @(negedge fclk);
    chk("rst_ym_cs_n", int'(bus_if.ym_cs_n), 3);
    chk("rst_saa_cs_n", int'(bus_if.saa_cs_n), 1);
    chk("rst_wr_n", int'(bus_if.wr_n), 1);
    chk("rst_bus_oe", int'(bus_if.bus_oe), 0);
    chk("rst_bus_d", int'(bus_if.bus_d), 0);
    chk("rst_bus_a0", int'(bus_if.bus_a0), 0);
    chk("rst_acks", int'({bus_if.z_ack, bus_if.a_ack}), 0);
    chk("rst_busy", int'(bus_if.busy), 0);
    @(posedge fclk); #1 rst_n = 1'b1;

    // Basic YM0 address write
    single(0, 2'd0, 1'b0, 8'h07);

    // Asynchronous reset during the second strobe cycle
    bus_if.z_sel = 2'd0; bus_if.z_a0 = 1'b1; bus_if.z_data = 8'($urandom); bus_if.z_req = 1'b1;
    got = 0;
    for (int i = 0; i < ACK_WAIT; i++) begin
      @(negedge fclk);
      if (!bus_if.wr_n) begin got = 1; break; end
    end
    if (!got) chk("strobe_timeout", 0, 1);
    @(posedge fclk); #1 rst_n = 1'b0;
    #1;
    chk("async_wr_n", int'(bus_if.wr_n), 1);
    chk("async_ym_cs_n", int'(bus_if.ym_cs_n), 3);
    chk("async_saa_cs_n", int'(bus_if.saa_cs_n), 1);
    chk("async_bus_oe", int'(bus_if.bus_oe), 0);
    chk("async_busy", int'(bus_if.busy), 0);
    bus_if.z_req = 1'b0;
    m_last = 1'b1;
    repeat (2) @(posedge fclk);
    #1 rst_n = 1'b1;

    // Simultaneous requests alternate
    both(2'd1, 1'b1, 8'($urandom), 2'd1, 1'b1, 8'($urandom));
    both(2'd1, 1'b1, 8'($urandom), 2'd1, 1'b1, 8'($urandom));

    // Null Z80 target beside a pending aux YM0 write
    both(2'd3, 1'b0, 8'($urandom), 2'd0, 1'b0, 8'($urandom));

    // SAA disabled then enabled
    bus_if.saa_enabled = 1'b0;
    single(1, 2'd2, 1'b0, 8'h1C);
    bus_if.saa_enabled = 1'b1;
    single(1, 2'd2, 1'b0, 8'h1C);

    // saa_enabled falls while the SAA write is on the bus
    push_exp(0, 2'd2, 1'b1, 8'hA5);
    fork
      run_req(0, 2'd2, 1'b1, 8'hA5);
      begin
        got = 0;
        for (int i = 0; i < ACK_WAIT; i++) begin
          @(negedge fclk);
          if (!bus_if.saa_cs_n) begin got = 1; break; end
        end
        if (!got) chk("saa_cs_timeout", 0, 1);
        @(posedge fclk); #1 bus_if.saa_enabled = 1'b0;
      end
    join
    bus_if.saa_enabled = 1'b1;

    // Back-to-back SAA writes with req held high
    bus_if.z_sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      bus_if.z_a0 = 1'($urandom); bus_if.z_data = 8'($urandom);
      push_exp(0, 2'd2, bus_if.z_a0, bus_if.z_data);
      bus_if.z_req = 1'b1;
      wait_ack(0);
      @(posedge fclk); #1;
    end
    bus_if.z_req = 1'b0;

    // Randomised rounds
    for (int r = 0; r < 10; r++) begin
      bus_if.saa_enabled = 1'($urandom);
      mode = $urandom_range(2, 0);
      zs = 2'($urandom); as = 2'($urandom);
      za = 1'($urandom); aa = 1'($urandom);
      d1 = 8'($urandom); d2 = 8'($urandom);
      if (mode == 0)      single(0, zs, za, d1);
      else if (mode == 1) single(1, as, aa, d2);
      else                both(zs, za, d1, as, aa, d2);
    end

    got = 0;
    for (int i = 0; i < ACK_WAIT; i++) begin
      @(negedge fclk);
      if (!bus_if.busy) begin got = 1; break; end
    end
    chk("final_idle", int'(got), 1);
    chk("queue_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
